// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
//
// Digital glitch filter for slow open-drain lines such as I2C SCL/SDA.
// Each channel is synchronised, then sampled into a DEPTH-bit window at
// a rate set by a shared prescaler. The filtered level only changes once the
// whole window agrees on the new value. A window that goes non-uniform and
// then settles back on the current filtered level is counted as a glitch.
//
// Parameters
//   CH          number of independent channels (ch0=SCL, ch1=SDA)
//   DEPTH       filter window length in samples
//   SYNC_STAGES synchroniser flops per channel (0 = none)
//   PRESCALE    clocks per filter sample
//   GCNT_W      width of each saturating glitch counter
//   INIT        reset level of windows, synchronisers and filtered outputs
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   sig         raw asynchronous line inputs
//   bypass      1 = filtering disabled, synchronised pass-through
//   glitch_clr  synchronous clear of all glitch counters
//   fsig        filtered line levels (registered)
//   ne / pe     one-clock pulses on fsig falling / rising transitions
//   glitch_cnt  per-channel glitch counts, channel n at [n*GCNT_W +: GCNT_W]
// -----------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int   CH          = 2,
  parameter int   DEPTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   PRESCALE    = 1,
  parameter int   GCNT_W      = 8,
  parameter logic INIT        = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH-1:0]        sig,
  input  logic                 bypass,
  input  logic                 glitch_clr,
  output logic [CH-1:0]        fsig,
  output logic [CH-1:0]        ne,
  output logic [CH-1:0]        pe,
  output logic [CH*GCNT_W-1:0] glitch_cnt
);

  localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [CH-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = sig;
    end else begin : g_sync
      logic [CH-1:0] sync_q [SYNC_STAGES];
      logic [CH-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = sig;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, whatever the block order.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= {CH{INIT}};
          end
        end else begin
          sync_q <= sync_d;
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Shared sample prescaler
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0] ps_q, ps_d;
  logic            sample_en;

  always_comb begin
    sample_en = (ps_q == PS_LAST);
    ps_d      = sample_en ? '0 : ps_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Per-channel window, filtered level, edge pulses and glitch counters
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]  win_q  [CH];
  logic [DEPTH-1:0]  win_d  [CH];
  logic [GCNT_W-1:0] cnt_q  [CH];
  logic [GCNT_W-1:0] cnt_d  [CH];
  logic [CH-1:0]     fsig_q, fsig_d;
  logic [CH-1:0]     pe_q, pe_d;
  logic [CH-1:0]     ne_q, ne_d;
  logic [CH-1:0]     dist_q, dist_d;
  logic [CH-1:0]     all_one, all_zero;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    win_d    = win_q;
    cnt_d    = cnt_q;
    fsig_d   = fsig_q;
    pe_d     = '0;
    ne_d     = '0;
    dist_d   = '0;
    all_one  = '0;
    all_zero = '0;

    for (int n = 0; n < CH; n++) begin
      all_one[n]  = &win_q[n];
      all_zero[n] = ~|win_q[n];

      // Newest sample enters at the MSB; the window keeps shifting in bypass
      // so it is already meaningful when filtering is re-enabled.
      if (sample_en) begin
        win_d[n] = {s[n], win_q[n][DEPTH-1:1]};
      end

      if (bypass) begin
        fsig_d[n] = s[n];
      end else if (all_one[n]) begin
        fsig_d[n] = 1'b1;
      end else if (all_zero[n]) begin
        fsig_d[n] = 1'b0;
      end

      pe_d[n]   = fsig_d[n] & ~fsig_q[n];
      ne_d[n]   = ~fsig_d[n] & fsig_q[n];
      dist_d[n] = ~bypass & ~(all_one[n] | all_zero[n]);

      // A disturbance that settles back on the current level is a glitch;
      // settling on the opposite level is a real transition and not counted.
      if (glitch_clr) begin
        cnt_d[n] = '0;
      end else if (!bypass && dist_q[n] && (all_one[n] | all_zero[n]) &&
                   (all_one[n] == fsig_q[n]) && (cnt_q[n] != GCNT_MAX)) begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  // NOTE: the window array is a bank of flops rather than a RAM, so it is
  // reset like any other state; loading INIT keeps the first filtered output
  // equal to the idle level and avoids a spurious edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q   <= '0;
      fsig_q <= {CH{INIT}};
      pe_q   <= '0;
      ne_q   <= '0;
      dist_q <= '0;
      for (int n = 0; n < CH; n++) begin
        win_q[n] <= {DEPTH{INIT}};
        cnt_q[n] <= '0;
      end
    end else begin
      ps_q   <= ps_d;
      fsig_q <= fsig_d;
      pe_q   <= pe_d;
      ne_q   <= ne_d;
      dist_q <= dist_d;
      win_q  <= win_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fsig = fsig_q;
  assign pe   = pe_q;
  assign ne   = ne_q;

  generate
    for (genvar g = 0; g < CH; g++) begin : g_cnt_out
      assign glitch_cnt[g*GCNT_W +: GCNT_W] = cnt_q[g];
    end
  endgenerate

endmodule
